// File: rtl/sha1_msg_padder.sv
// Packs a big-endian 32-bit word stream into 512-bit SHA-1 blocks with marker, zero fill
// and 64-bit bit length. Word 0 of the block sits at block_data[511:480].
module sha1_msg_padder (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic         in_ready,
  output logic [511:0] block_data,
  output logic         block_start,
  output logic         block_first,
  output logic         block_last,
  input  logic         block_done,
  output logic         busy
);
  typedef enum logic [1:0] {S_FILL, S_PAD, S_ISSUE, S_WAIT} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_buf [16];
  logic [3:0]  r_idx;
  logic [63:0] r_len;
  logic        r_marker, r_len_ok, r_first, r_msg_done, r_busy, r_blk_first, r_blk_last;

  logic [2:0]  w_nb;
  logic [31:0] w_last_word, w_in_word, w_pad_word;
  logic [63:0] w_len_add;
  logic        w_acc, w_pad_last;

  assign w_nb       = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
  assign w_in_word  = in_last ? w_last_word : in_data;
  assign w_len_add  = in_last ? {58'd0, w_nb, 3'd0} : 64'd32;
  assign w_acc      = in_valid && (r_state == S_FILL);
  assign w_pad_last = r_marker && r_len_ok && (r_idx == 4'd15);

  // Partial final word: keep the valid bytes, then the 0x80 marker, then zeros.
  always_comb begin
    w_last_word = in_data;
    case (w_nb)
      3'd0:    w_last_word = 32'h8000_0000;
      3'd1:    w_last_word = {in_data[31:24], 8'h80, 16'h0000};
      3'd2:    w_last_word = {in_data[31:16], 8'h80, 8'h00};
      3'd3:    w_last_word = {in_data[31:8], 8'h80};
      default: w_last_word = in_data;
    endcase
  end

  always_comb begin
    if (!r_marker)                        w_pad_word = 32'h8000_0000;
    else if (r_len_ok && r_idx == 4'd14)  w_pad_word = r_len[63:32];
    else if (r_len_ok && r_idx == 4'd15)  w_pad_word = r_len[31:0];
    else                                  w_pad_word = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FILL;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FILL:  if (w_acc) begin
                 if (r_idx == 4'd15) w_next = S_ISSUE;
                 else if (in_last)   w_next = S_PAD;
               end
      S_PAD:   if (r_idx == 4'd15) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (block_done) begin
                 if (r_blk_last)      w_next = S_FILL;
                 else if (r_msg_done) w_next = S_PAD;
                 else                 w_next = S_FILL;
               end
      default: w_next = S_FILL;
    endcase
  end

  always_comb begin
    in_ready    = (r_state == S_FILL) && !reset;
    block_start = (r_state == S_ISSUE);
    block_first = r_blk_first;
    block_last  = r_blk_last;
    busy        = r_busy;
    block_data  = '0;
    for (int i = 0; i < 16; i++) block_data[511-32*i -: 32] = r_buf[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) r_buf[i] <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_marker    <= 1'b0;
      r_len_ok    <= 1'b0;
      r_first     <= 1'b1;
      r_msg_done  <= 1'b0;
      r_busy      <= 1'b0;
      r_blk_first <= 1'b0;
      r_blk_last  <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: if (w_acc) begin
          r_buf[r_idx] <= w_in_word;
          r_len        <= r_len + w_len_add;
          r_busy       <= 1'b1;
          r_idx        <= r_idx + 4'd1;
          if (in_last) begin
            r_msg_done <= 1'b1;
            r_marker   <= (w_nb != 3'd4);
            if (w_nb != 3'd4) r_len_ok <= (r_idx <= 4'd13);
          end
          if (r_idx == 4'd15) begin
            r_blk_first <= r_first;
            r_blk_last  <= 1'b0;
          end
        end
        S_PAD: begin
          r_buf[r_idx] <= w_pad_word;
          r_idx        <= r_idx + 4'd1;
          if (!r_marker) begin
            r_marker <= 1'b1;
            r_len_ok <= (r_idx <= 4'd13);
          end
          if (r_idx == 4'd15) begin
            r_blk_first <= r_first;
            r_blk_last  <= w_pad_last;
          end
        end
        S_WAIT: if (block_done) begin
          r_idx   <= '0;
          r_first <= 1'b0;
          if (r_blk_last) begin
            r_first    <= 1'b1;
            r_len      <= '0;
            r_busy     <= 1'b0;
            r_msg_done <= 1'b0;
            r_marker   <= 1'b0;
            r_len_ok   <= 1'b0;
          end else if (r_msg_done) begin
            // Overflow block: the length always fits in the fresh one.
            r_len_ok <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sha1_msg_padder.sv
// Directed bench for sha1_msg_padder: expected blocks queued at stimulus time,
// a monitor pops and compares on every block_start, a core model answers with block_done.
module tb_sha1_msg_padder;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic [2:0]   in_nbytes = '0;
  logic         in_ready;
  logic [511:0] block_data;
  logic         block_start, block_first, block_last;
  logic         block_done = 1'b0;
  logic         busy;

  sha1_msg_padder dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_nbytes(in_nbytes), .in_ready(in_ready), .block_data(block_data),
    .block_start(block_start), .block_first(block_first), .block_last(block_last),
    .block_done(block_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [511:0] data; logic first; logic last; } blk_t;
  blk_t        exp_q[$];
  logic [31:0] ew [16];
  int          n_vec = 0, n_bad = 0;
  int          done_cnt = 0, rst_cnt = 0;
  int          stall = 0, done_at_acc = 0;

  always @(posedge reset) rst_cnt++;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  task automatic clear_ew();
    for (int i = 0; i < 16; i++) ew[i] = '0;
  endtask

  task automatic push_exp(input logic first, input logic last);
    blk_t b;
    b.data = '0;
    for (int i = 0; i < 16; i++) b.data[511-32*i -: 32] = ew[i];
    b.first = first;
    b.last  = last;
    exp_q.push_back(b);
  endtask

  // Called on a negedge; returns on the negedge after the word is accepted.
  task automatic send(input logic [31:0] d, input logic last, input logic [2:0] n);
    int w;
    w = 0;
    in_data = d; in_last = last; in_nbytes = n; in_valid = 1'b1;
    while (!in_ready && w < 300) begin @(negedge clk); w++; end
    if (!in_ready) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout: in_ready=%b, expected 1", in_ready);
    end else begin
      stall = w;
      done_at_acc = done_cnt;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_words(input int n);
    for (int i = 0; i < n; i++) send(pat(i), 1'b0, 3'd4);
  endtask

  // Cycles from the accept cycle (0) to the block_start cycle.
  task automatic meas_lat(input int exp_lat);
    int lat;
    lat = 1;
    while (!block_start && lat < 100) begin @(negedge clk); lat++; end
    chk("last_to_start", 512'(lat), 512'(exp_lat));
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || busy) && w < 500) begin @(negedge clk); w++; end
    chk("idle_queue_empty", 512'(exp_q.size()), 512'(0));
    chk("idle_busy", 512'(busy), 512'(0));
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && block_start) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_block: got block %h, expected none", block_data);
      end else begin
        blk_t e;
        e = exp_q.pop_front();
        chk("block_data", block_data, e.data);
        chk("block_first", 512'(block_first), 512'(e.first));
        chk("block_last", 512'(block_last), 512'(e.last));
      end
    end
  end

  // Core model: consume the block a few cycles after start, then pulse done.
  always begin
    @(negedge clk);
    if (!reset && block_start) begin
      logic [511:0] snap;
      int           rc;
      snap = block_data;
      rc   = rst_cnt;
      repeat (3) @(negedge clk);
      if (rc == rst_cnt && !reset) begin
        chk("wait_hold_data", block_data, snap);
        block_done = 1'b1;
        done_cnt++;
        @(negedge clk);
        block_done = 1'b0;
      end
    end
  end

  initial begin
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 512'(in_ready), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_start", 512'(block_start), 512'(0));
    chk("rst_first", 512'(block_first), 512'(0));
    chk("rst_last", 512'(block_last), 512'(0));
    chk("rst_data", block_data, 512'(0));
    reset = 1'b0;
    #1 chk("rel_in_ready", 512'(in_ready), 512'(1));
    @(negedge clk);

    // "abc"
    clear_ew(); ew[0] = 32'h6162_6380; ew[15] = 32'h0000_0018; push_exp(1'b1, 1'b1);
    send(32'h6162_6300, 1'b1, 3'd3);
    chk("busy_after_accept", 512'(busy), 512'(1));
    meas_lat(16);
    wait_idle();

    // empty message
    clear_ew(); ew[0] = 32'h8000_0000; push_exp(1'b1, 1'b1);
    send(32'hFFFF_FFFF, 1'b1, 3'd0);
    wait_idle();

    // 55 bytes
    clear_ew();
    for (int i = 0; i < 13; i++) ew[i] = pat(i);
    ew[13] = 32'h1122_3380; ew[15] = 32'h0000_01B8; push_exp(1'b1, 1'b1);
    send_words(13);
    send(32'h1122_3344, 1'b1, 3'd3);
    meas_lat(3);
    wait_idle();

    // 56 bytes: length spills into a second block
    clear_ew();
    for (int i = 0; i < 14; i++) ew[i] = pat(i);
    ew[14] = 32'h8000_0000; push_exp(1'b1, 1'b0);
    clear_ew(); ew[15] = 32'h0000_01C0; push_exp(1'b0, 1'b1);
    send_words(14);
    send(32'hDEAD_BEEF, 1'b1, 3'd0);
    meas_lat(2);
    wait_idle();

    // 64 bytes (final n given as 7, i.e. full), then "abc" held against backpressure
    clear_ew();
    for (int i = 0; i < 16; i++) ew[i] = pat(i);
    push_exp(1'b1, 1'b0);
    clear_ew(); ew[0] = 32'h8000_0000; ew[15] = 32'h0000_0200; push_exp(1'b0, 1'b1);
    clear_ew(); ew[0] = 32'h6162_6380; ew[15] = 32'h0000_0018; push_exp(1'b1, 1'b1);
    send_words(15);
    send(pat(15), 1'b1, 3'd7);
    send(32'h6162_6300, 1'b1, 3'd3);
    chk("stall_seen", 512'(stall > 0), 512'(1));
    chk("accept_after_done", 512'(done_at_acc), 512'(7));
    wait_idle();

    // reset while waiting on the core
    clear_ew();
    for (int i = 0; i < 16; i++) ew[i] = pat(i);
    push_exp(1'b1, 1'b0);
    send_words(15);
    send(pat(15), 1'b1, 3'd4);
    begin
      int w;
      w = 0;
      while (!block_start && w < 50) begin @(negedge clk); w++; end
      chk("pre_reset_start", 512'(block_start), 512'(1));
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 512'(busy), 512'(0));
    chk("midrst_in_ready", 512'(in_ready), 512'(0));
    chk("midrst_data", block_data, 512'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("postrst_in_ready", 512'(in_ready), 512'(1));
    chk("postrst_busy", 512'(busy), 512'(0));
    @(negedge clk);
    clear_ew(); ew[0] = 32'h6162_6380; ew[15] = 32'h0000_0018; push_exp(1'b1, 1'b1);
    send(32'h6162_6300, 1'b1, 3'd3);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end
endmodule
